// File: rtl/level_pkg.sv
// Shared types and per-level tuning for the Bumpy progression controller.
package level_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_FLAG_UP,
    ST_LEVEL_DONE,
    ST_WON
  } state_e;

  localparam int NUM_LEVELS_DEF = 4;

  // Score needed to raise the finish flag, indexed by level; entries past
  // the configured level count are spare.
  localparam int LEVEL_THRESH [8] = '{4, 6, 8, 10, 12, 14, 15, 15};

endpackage

// File: rtl/frame_tick_counter.sv
// Counts startOfFrame ticks from 0 to TERM and flags the tick that completes a run.
module frame_tick_counter #(
  parameter int TERM = 59
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  output logic last_o
);

  localparam int CW = (TERM < 1) ? 1 : $clog2(TERM + 1);

  logic [CW-1:0] cnt_q;

  assign last_o = tick_i && !clr_i && (cnt_q == CW'(TERM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || last_o) begin
      cnt_q <= '0;
    end else if (tick_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/level_progress_ctrl.sv
// Game progression controller: score, level, finish flag and level-complete pause.
// Optional flag blinking in FLAG_UP is enabled by defining FLAG_BLINK_EN.
module level_progress_ctrl
  import level_pkg::*;
#(
  parameter int NUM_LEVELS   = NUM_LEVELS_DEF,
  parameter int SCORE_W      = 4,
  parameter int DONE_FRAMES  = 60,
  parameter int BLINK_FRAMES = 8,
  localparam int LVL_W       = $clog2(NUM_LEVELS)
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               gameStart,
  input  logic               scoreInc,
  input  logic               playerDead,
  input  logic               flagHit,
  output logic [LVL_W-1:0]   levelCode,
  output logic [SCORE_W-1:0] score,
  output logic               flagEnable,
  output logic               levelDone,
  output logic               gameWon
);

  localparam int              SMAX_I = (1 << SCORE_W) - 1;
  localparam logic [SCORE_W-1:0] SMAX = '1;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic inc);
    if (inc && (s != SMAX)) return s + SCORE_W'(1);
    return s;
  endfunction

  // Thresholds above the representable score are clamped so the flag stays reachable.
  function automatic logic [SCORE_W-1:0] thresh_of(input logic [LVL_W-1:0] lvl);
    logic [2:0] idx;
    int         t;
    idx = 3'(lvl);
    t   = LEVEL_THRESH[idx];
    if (t > SMAX_I) t = SMAX_I;
    return SCORE_W'(t);
  endfunction

  state_e             state_q;
  logic [LVL_W-1:0]   levelCode_q;
  logic [SCORE_W-1:0] score_q;
  logic               flagEnable_q;
  logic               levelDone_q;
  logic               gameWon_q;

  logic [SCORE_W-1:0] score_inc;
  logic               play_hit;
  logic               done_last;
  logic               blink_on;

  assign score_inc = sat_inc(score_q, scoreInc);
  assign play_hit  = (score_inc >= thresh_of(levelCode_q));

  frame_tick_counter #(
    .TERM (DONE_FRAMES - 1)
  ) u_done_cnt (
    .clk    (clk),
    .rst_n  (resetN),
    .clr_i  (gameStart || (state_q != ST_LEVEL_DONE)),
    .tick_i (startOfFrame),
    .last_o (done_last)
  );

`ifdef FLAG_BLINK_EN
  logic       blink_phase_q;
  logic [3:0] toggles_q;
  logic       blink_last;
  logic       blink_step;

  frame_tick_counter #(
    .TERM (BLINK_FRAMES - 1)
  ) u_blink_cnt (
    .clk    (clk),
    .rst_n  (resetN),
    .clr_i  (state_q != ST_FLAG_UP),
    .tick_i (startOfFrame),
    .last_o (blink_last)
  );

  assign blink_step = blink_last && (toggles_q < 4'd8);
  assign blink_on   = blink_step ? ~blink_phase_q : blink_phase_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_phase_q <= 1'b1;
      toggles_q     <= '0;
    end else if (state_q != ST_FLAG_UP) begin
      blink_phase_q <= 1'b1;
      toggles_q     <= '0;
    end else if (blink_step) begin
      blink_phase_q <= ~blink_phase_q;
      toggles_q     <= toggles_q + 4'd1;
    end
  end
`else
  assign blink_on = (BLINK_FRAMES >= 1);
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      levelCode_q  <= '0;
      score_q      <= '0;
      flagEnable_q <= 1'b0;
      levelDone_q  <= 1'b0;
      gameWon_q    <= 1'b0;
    end else begin
      levelDone_q <= 1'b0;
      if (gameStart) begin
        state_q      <= ST_PLAY;
        levelCode_q  <= '0;
        score_q      <= '0;
        flagEnable_q <= 1'b0;
        gameWon_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (playerDead) begin
              score_q <= '0;
            end else begin
              score_q <= score_inc;
              if (play_hit) begin
                state_q      <= ST_FLAG_UP;
                flagEnable_q <= 1'b1;
              end
            end
          end
          ST_FLAG_UP: begin
            if (playerDead) begin
              score_q      <= '0;
              state_q      <= ST_PLAY;
              flagEnable_q <= 1'b0;
            end else begin
              score_q <= score_inc;
              if (flagHit) begin
                state_q      <= ST_LEVEL_DONE;
                levelDone_q  <= 1'b1;
                flagEnable_q <= 1'b0;
              end else begin
                flagEnable_q <= blink_on;
              end
            end
          end
          ST_LEVEL_DONE: begin
            if (done_last) begin
              if (levelCode_q == LVL_W'(NUM_LEVELS - 1)) begin
                state_q   <= ST_WON;
                gameWon_q <= 1'b1;
              end else begin
                levelCode_q <= levelCode_q + LVL_W'(1);
                score_q     <= '0;
                state_q     <= ST_PLAY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign levelCode  = levelCode_q;
  assign score      = score_q;
  assign flagEnable = flagEnable_q;
  assign levelDone  = levelDone_q;
  assign gameWon    = gameWon_q;

endmodule

// File: tb/tb_level_progress_ctrl.sv
// Self-checking bench for level_progress_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural game model.
module tb_level_progress_ctrl;

  localparam int NL   = 4;
  localparam int SW   = 4;
  localparam int DF   = 60;
  localparam int BF   = 8;
  localparam int SMAX = 15;

  int thr [4] = '{4, 6, 8, 10};

  logic          clk;
  logic          resetN;
  logic          startOfFrame, gameStart, scoreInc, playerDead, flagHit;
  logic [1:0]    levelCode;
  logic [SW-1:0] score;
  logic          flagEnable, levelDone, gameWon;

  level_progress_ctrl #(
    .NUM_LEVELS   (NL),
    .SCORE_W      (SW),
    .DONE_FRAMES  (DF),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .gameStart    (gameStart),
    .scoreInc     (scoreInc),
    .playerDead   (playerDead),
    .flagHit      (flagHit),
    .levelCode    (levelCode),
    .score        (score),
    .flagEnable   (flagEnable),
    .levelDone    (levelDone),
    .gameWon      (gameWon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Behavioural game model
  bit m_active, m_flag, m_paused, m_won, m_ld, m_phase;
  int m_lvl, m_score, m_frames, m_bsof, m_tog;

  task automatic model_reset();
    m_active = 0; m_flag = 0; m_paused = 0; m_won = 0; m_ld = 0; m_phase = 1;
    m_lvl = 0; m_score = 0; m_frames = 0; m_bsof = 0; m_tog = 0;
  endtask

  task automatic model_step(input bit gs, input bit sof, input bit inc,
                            input bit dead, input bit hit);
    m_ld = 0;
    if (gs) begin
      m_active = 1; m_flag = 0; m_paused = 0; m_won = 0;
      m_lvl = 0; m_score = 0; m_frames = 0;
    end else if (m_paused) begin
      if (sof) begin
        m_frames++;
        if (m_frames == DF) begin
          m_paused = 0;
          if (m_lvl == NL - 1) begin
            m_won = 1; m_active = 0;
          end else begin
            m_lvl++; m_score = 0;
          end
        end
      end
    end else if (m_active) begin
      if (dead) begin
        m_score = 0; m_flag = 0;
      end else begin
        if (inc && m_score < SMAX) m_score++;
        if (m_flag) begin
          if (hit) begin
            m_flag = 0; m_paused = 1; m_frames = 0; m_ld = 1;
          end else begin
`ifdef FLAG_BLINK_EN
            if (sof) begin
              m_bsof++;
              if (m_bsof == BF) begin
                m_bsof = 0;
                if (m_tog < 8) begin
                  m_tog++; m_phase = !m_phase;
                end
              end
            end
`endif
          end
        end else if (m_score >= thr[m_lvl]) begin
          m_flag = 1; m_phase = 1; m_bsof = 0; m_tog = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_level"}, 32'(levelCode), 32'(m_lvl));
    check({tag, "_score"}, 32'(score), 32'(m_score));
    check({tag, "_flag"},  32'(flagEnable), 32'(m_flag && m_phase));
    check({tag, "_done"},  32'(levelDone), 32'(m_ld));
    check({tag, "_won"},   32'(gameWon), 32'(m_won));
  endtask

  task automatic cyc(input bit gs, input bit sof, input bit inc, input bit dead, input bit hit);
    @(negedge clk);
    gameStart = gs; startOfFrame = sof; scoreInc = inc; playerDead = dead; flagHit = hit;
    @(posedge clk);
    model_step(gs, sof, inc, dead, hit);
    #1;
    compare_all("cyc");
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic pause_frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0, 0);
      idle();
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 0; gameStart = 0; scoreInc = 0; playerDead = 0; flagHit = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    resetN = 1'b1;

    // start and reach the level-0 threshold
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0);
    check("t1_score", 32'(score), 32'd4);
    check("t1_flag", 32'(flagEnable), 32'd1);
    check("t1_level", 32'(levelCode), 32'd0);

    // accept flag, pause, advance to level 1
    cyc(0, 0, 0, 0, 1);
    check("t2_done_pulse", 32'(levelDone), 32'd1);
    check("t2_flag_off", 32'(flagEnable), 32'd0);
    idle();
    check("t2_done_clear", 32'(levelDone), 32'd0);
    pause_frames(DF - 1);
    check("t2_still_level0", 32'(levelCode), 32'd0);
    pause_frames(1);
    check("t2_level1", 32'(levelCode), 32'd1);
    check("t2_score0", 32'(score), 32'd0);
    repeat (5) cyc(0, 0, 1, 0, 0);
    check("t2_no_flag_at5", 32'(flagEnable), 32'd0);
    cyc(0, 0, 1, 0, 0);
    check("t2_flag_at6", 32'(flagEnable), 32'd1);

    // death overrides a simultaneous point and a simultaneous flag hit
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    check("t3_score0", 32'(score), 32'd0);
    check("t3_flag0", 32'(flagEnable), 32'd0);
    repeat (4) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    check("t3_no_done", 32'(levelDone), 32'd0);
    check("t3_flag_dead", 32'(flagEnable), 32'd0);

    // play through all levels
    cyc(1, 0, 0, 0, 0);
    for (int l = 0; l < NL; l++) begin
      for (int k = 0; k < thr[l]; k++) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);
      pause_frames(DF);
    end
    check("t4_won", 32'(gameWon), 32'd1);
    check("t4_flag", 32'(flagEnable), 32'd0);
    repeat (3) cyc(0, 1, 1, 0, 1);
    cyc(1, 0, 0, 0, 0);
    check("t4_won_cleared", 32'(gameWon), 32'd0);
    check("t4_level0", 32'(levelCode), 32'd0);

    // saturation, then reset in the middle of the pause
    repeat (20) cyc(0, 0, 1, 0, 0);
    check("t5_sat", 32'(score), 32'd15);
    cyc(0, 0, 0, 0, 1);
    pause_frames(10);
    async_reset("t5_async");
    check("t5_score_rst", 32'(score), 32'd0);

    // random traffic
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 2999) == 0) begin
        async_reset("rnd_async");
      end else begin
        cyc($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
